// File: rtl/wb_bridge_nway.sv
// wb_bridge_nway: N-way Wishbone classic bridge with registered request and
// response paths, sentinel data for unmapped accesses and a saturating error
// counter. Define WB_BRIDGE_TIMEOUT_EN to abandon a downstream access that
// stays unacknowledged for TIMEOUT busy cycles.
module wb_bridge_nway #(
    parameter int unsigned N_PORTS    = 4,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned SEL_LSB    = 24,
    parameter int unsigned SEL_BITS   = 2,
    parameter logic [31:0] DEAD_DATA  = 32'hDEAD_BEEF,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_dat_i,
    input  logic [31:0]             wbs_adr_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [N_PORTS-1:0]      wbm_stb_o,
    output logic [N_PORTS-1:0]      wbm_cyc_o,
    output logic                    wbm_we_o,
    output logic [3:0]              wbm_sel_o,
    output logic [31:0]             wbm_dat_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    input  logic [N_PORTS-1:0]      wbm_ack_i,
    input  logic [32*N_PORTS-1:0]   wbm_dat_i,
    output logic [7:0]              err_cnt_o
);

    // Parameter sanity checks, resolved at elaboration
    if (N_PORTS < 1 || N_PORTS > 16 || (1 << SEL_BITS) < N_PORTS || TIMEOUT == 0) begin : g_bad_params
        $error("wb_bridge_nway: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  r_state;
    logic [SEL_BITS-1:0]     r_idx;
    logic [N_PORTS-1:0]      r_stb;
    logic                    r_we;
    logic [3:0]              r_sel;
    logic [31:0]             r_dat;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic                    r_ack;
    logic [31:0]             r_rdat;
    logic [7:0]              r_err;

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0]        r_tcnt;
`endif

    logic [SEL_BITS-1:0]     w_idx;
    logic                    w_mapped;
    logic [N_PORTS-1:0]      w_onehot;
    logic                    w_ack_sel;
    logic [31:0]             w_rdat_sel;
    logic                    w_unused_adr;

    assign w_idx        = wbs_adr_i[SEL_LSB +: SEL_BITS];
    assign w_mapped     = 32'(w_idx) < 32'(N_PORTS);
    assign w_unused_adr = ^wbs_adr_i;

    // Port decode of the incoming address and mux of the selected port's ack/data
    always_comb begin
        w_onehot   = '0;
        w_ack_sel  = 1'b0;
        w_rdat_sel = 32'h0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            w_onehot[k] = (w_idx == SEL_BITS'(k));
            if (r_idx == SEL_BITS'(k)) begin
                w_ack_sel  = wbm_ack_i[k];
                w_rdat_sel = wbm_dat_i[32*k +: 32];
            end
        end
    end

    // Bridge FSM; every output is a register updated here
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_stb   <= '0;
            r_we    <= 1'b0;
            r_sel   <= 4'h0;
            r_dat   <= 32'h0;
            r_adr   <= '0;
            r_ack   <= 1'b0;
            r_rdat  <= 32'h0;
            r_err   <= 8'h0;
`ifdef WB_BRIDGE_TIMEOUT_EN
            r_tcnt  <= '0;
`endif
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (wbs_cyc_i && wbs_stb_i) begin
                        r_we  <= wbs_we_i;
                        r_sel <= wbs_sel_i;
                        r_dat <= wbs_dat_i;
                        r_adr <= wbs_adr_i[ADDR_WIDTH-1:0];
                        r_idx <= w_idx;
                        if (w_mapped) begin
                            r_stb   <= w_onehot;
                            r_state <= BUSY;
`ifdef WB_BRIDGE_TIMEOUT_EN
                            r_tcnt  <= '0;
`endif
                        end else begin
                            r_rdat  <= DEAD_DATA;
                            r_ack   <= 1'b1;
                            r_state <= RESP;
                            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                        end
                    end
                end
                BUSY: begin
                    if (!wbs_cyc_i) begin
                        // Master abandoned the cycle: release the target silently
                        r_stb   <= '0;
                        r_state <= IDLE;
                    end else if (w_ack_sel) begin
                        r_rdat  <= w_rdat_sel;
                        r_stb   <= '0;
                        r_ack   <= 1'b1;
                        r_state <= RESP;
                    end
`ifdef WB_BRIDGE_TIMEOUT_EN
                    else if (r_tcnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rdat  <= DEAD_DATA;
                        r_stb   <= '0;
                        r_ack   <= 1'b1;
                        r_state <= RESP;
                        if (r_err != 8'hFF) r_err <= r_err + 8'd1;
                    end else begin
                        r_tcnt  <= r_tcnt + CNT_W'(1);
                    end
`endif
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_stb   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdat;
    assign wbm_stb_o = r_stb;
    assign wbm_cyc_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_dat_o = r_dat;
    assign wbm_adr_o = r_adr;
    assign err_cnt_o = r_err;

endmodule

// File: tb/tb_wb_bridge_nway.sv
// Bench for wb_bridge_nway: directed transfers with a queue-based scoreboard.
// Build with WB_BRIDGE_TIMEOUT_EN defined to also exercise the timeout path.
module tb_wb_bridge_nway;

    localparam int unsigned NP = 4;
    localparam int unsigned AW = 11;

    logic               clk;
    logic               rst_n;
    logic               wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]         wbs_sel_i;
    logic [31:0]        wbs_dat_i, wbs_adr_i;
    logic               wbs_ack_o;
    logic [31:0]        wbs_dat_o;
    logic [NP-1:0]      wbm_stb_o, wbm_cyc_o;
    logic               wbm_we_o;
    logic [3:0]         wbm_sel_o;
    logic [31:0]        wbm_dat_o;
    logic [AW-1:0]      wbm_adr_o;
    logic [NP-1:0]      wbm_ack_i;
    logic [32*NP-1:0]   wbm_dat_i;
    logic [7:0]         err_cnt_o;

    wb_bridge_nway #(
        .N_PORTS(NP), .ADDR_WIDTH(AW), .SEL_LSB(24), .SEL_BITS(3),
        .DEAD_DATA(32'hDEAD_BEEF), .TIMEOUT(16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o), .wbm_adr_o(wbm_adr_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .err_cnt_o(err_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic [7:0]  err;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  exp_err = 8'h0;

    // Downstream slave model: each port acks ack_delay cycles after its strobe rises
    logic [31:0] port_data [NP];
    int          ack_delay = 0;
    logic [NP-1:0] spur = '0;
    int          stb_cnt = 0;

    always @(posedge clk) begin
        if (|wbm_stb_o) stb_cnt <= stb_cnt + 1;
        else            stb_cnt <= 0;
    end

    always_comb begin
        for (int k = 0; k < int'(NP); k++) wbm_dat_i[32*k +: 32] = port_data[k];
        wbm_ack_i = ((stb_cnt >= ack_delay) ? wbm_stb_o : '0) | spur;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every upstream ack is matched against the queue
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        if (wbs_ack_o === 1'b1) begin
            chk("ack_single_cycle", 32'(prev_ack), 32'h0);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack with empty queue (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("rd_data", wbs_dat_o, e.dat);
                chk("err_cnt_at_ack", 32'(err_cnt_o), 32'(e.err));
            end
        end
        prev_ack = wbs_ack_o;
    end

    // One upstream transfer: checks downstream qualifiers and ack latency
    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] dat, input logic [NP-1:0] exp_stb,
                        input logic [31:0] exp_rd, input int exp_lat, input bit err_inc);
        exp_t e;
        int   n;
        if (err_inc && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        e.dat = exp_rd;
        e.err = exp_err;
        sb_q.push_back(e);
        @(negedge clk);
        wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("wbm_stb", 32'(wbm_stb_o), 32'(exp_stb));
                chk("wbm_cyc", 32'(wbm_cyc_o), 32'(exp_stb));
                if (exp_stb != '0) begin
                    chk("wbm_adr", 32'(wbm_adr_o), 32'(adr[AW-1:0]));
                    chk("wbm_we", 32'(wbm_we_o), 32'(we));
                    chk("wbm_sel", 32'(wbm_sel_o), 32'(sel));
                    chk("wbm_dat", wbm_dat_o, dat);
                end
            end
            if (wbs_ack_o === 1'b1) break;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL ack_wait: no ack after %0d cycles, expected %0d", n, exp_lat);
                break;
            end
        end
        chk("ack_latency", 32'(n), 32'(exp_lat));
        @(posedge clk);
        #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        port_data[0] = 32'h0000_AAA0;
        port_data[1] = 32'h1234_5678;
        port_data[2] = 32'h2222_BBB2;
        port_data[3] = 32'hCAFE_0003;
        rst_n = 1'b0;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        wbs_sel_i = 4'h0; wbs_dat_i = 32'h0; wbs_adr_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(wbs_ack_o), 32'h0);
        chk("rst_dat", wbs_dat_o, 32'h0);
        chk("rst_stb", 32'(wbm_stb_o), 32'h0);
        chk("rst_err", 32'(err_cnt_o), 32'h0);
        rst_n = 1'b1;

        // Asynchronous reset while port 2 is busy
        ack_delay = 1000;
        @(negedge clk);
        wbs_adr_i = 32'h0200_0004; wbs_cyc_i = 1; wbs_stb_i = 1;
        @(negedge clk);
        chk("busy_stb_p2", 32'(wbm_stb_o), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_stb", 32'(wbm_stb_o), 32'h0);
        chk("async_rst_cyc", 32'(wbm_cyc_o), 32'h0);
        chk("async_rst_ack", 32'(wbs_ack_o), 32'h0);
        chk("async_rst_err", 32'(err_cnt_o), 32'h0);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Read port 1, slave acks one cycle after strobe
        ack_delay = 1;
        xfer(32'h0100_0010, 1'b0, 4'hF, 32'h0, 4'b0010, 32'h1234_5678, 3, 1'b0);

        // Write port 3 with a spurious ack on port 0 throughout
        ack_delay = 2;
        spur = 4'b0001;
        xfer(32'h0300_0020, 1'b1, 4'b0101, 32'hA5A5_0F0F, 4'b1000, 32'hCAFE_0003, 4, 1'b0);
        spur = '0;

        // Same-cycle acks on ports 0 and 2
        ack_delay = 0;
        xfer(32'h0000_07FC, 1'b0, 4'hF, 32'h0, 4'b0001, 32'h0000_AAA0, 2, 1'b0);
        xfer(32'h0200_0123, 1'b0, 4'h3, 32'h0, 4'b0100, 32'h2222_BBB2, 2, 1'b0);

        // Master abort during BUSY on port 1
        ack_delay = 1000;
        @(negedge clk);
        wbs_adr_i = 32'h0100_0000; wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
        @(negedge clk);
        chk("abort_busy_stb", 32'(wbm_stb_o), 32'h2);
        @(negedge clk);
        wbs_cyc_i = 0; wbs_stb_i = 0;
        @(negedge clk);
        chk("abort_cyc", 32'(wbm_cyc_o), 32'h0);
        chk("abort_stb", 32'(wbm_stb_o), 32'h0);
        repeat (3) @(negedge clk);
        ack_delay = 0;
        xfer(32'h0000_0004, 1'b0, 4'hF, 32'h0, 4'b0001, 32'h0000_AAA0, 2, 1'b0);

        // Unmapped select value
        xfer(32'h0400_0000, 1'b0, 4'hF, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1, 1'b1);
        chk("err_after_one", 32'(err_cnt_o), 32'h1);

`ifdef WB_BRIDGE_TIMEOUT_EN
        // Port 0 never acks: timeout after 16 busy cycles
        ack_delay = 1000;
        xfer(32'h0000_0008, 1'b0, 4'hF, 32'h0, 4'b0001, 32'hDEAD_BEEF, 17, 1'b1);
        // Ack in the 16th busy cycle beats the timeout
        ack_delay = 15;
        xfer(32'h0000_000C, 1'b0, 4'hF, 32'h0, 4'b0001, 32'h0000_AAA0, 17, 1'b0);
        chk("err_after_timeout", 32'(err_cnt_o), 32'h2);
        ack_delay = 0;
`endif

        // Saturation of the error counter
        for (int i = 0; i < 299; i++) begin
            xfer(32'((4 + (i % 4)) << 24) | 32'(i), 1'b0, 4'hF, 32'h0, 4'b0000,
                 32'hDEAD_BEEF, 1, 1'b1);
        end
        chk("err_saturated", 32'(err_cnt_o), 32'hFF);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
